// File: rtl/t07_tft_spi_writer.sv
`default_nettype none
// ============================================================================
//  Module      : t07_tft_spi_writer
//  Description : Serialises one TFT write request into an SPI mode-0 frame:
//                one command byte (dc low) followed by 0..4 data bytes
//                (dc high), then returns a single-cycle ack_TFT pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module t07_tft_spi_writer #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wi_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  output logic        ack_TFT,
  output logic        busy,
  output logic        tft_cs_n,
  output logic        tft_sclk,
  output logic        tft_mosi,
  output logic        tft_dc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_div;       // cycles spent in the current SCLK half-period
  logic        r_phase;     // 0 = low half, 1 = high half
  logic [5:0]  r_bit_cnt;   // bits already shifted out of the frame (0..39)
  logic [39:0] r_shift;     // frame, MSB is the bit currently on mosi
  logic [2:0]  r_n;         // latched data byte count, already clamped

  logic        w_shifting;
  logic        w_bit_end;
  logic        w_last_cmd;
  logic        w_last_bit;
  logic [2:0]  w_n_clamp;
  logic [5:0]  w_pad;
  logic [31:0] w_payload;

  // Address bits above the byte count carry no meaning for this block.
  logic        unused_addr;
  assign unused_addr = ^addr_in[31:11];

  // Byte count clamps to 4; the payload is left-aligned so the first data
  // byte to be sent sits directly behind the command byte.
  assign w_n_clamp  = (addr_in[10:8] > 3'd4) ? 3'd4 : addr_in[10:8];
  assign w_pad      = 6'd32 - {w_n_clamp, 3'b000};
  assign w_payload  = data_in << w_pad;

  assign w_shifting = (r_state == ST_CMD) || (r_state == ST_DATA);
  assign w_bit_end  = r_phase && (r_div == c_div_last);
  assign w_last_cmd = (r_bit_cnt == 6'd7);
  assign w_last_bit = (r_bit_cnt == ({r_n, 3'b000} + 6'd7));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    w_state_next = r_state;
    ack_TFT      = 1'b0;
    busy         = 1'b0;
    tft_cs_n     = 1'b1;
    tft_sclk     = 1'b0;
    tft_mosi     = 1'b0;
    tft_dc       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wi_in) begin
          w_state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        busy     = 1'b1;
        tft_cs_n = 1'b0;
        tft_sclk = r_phase;
        tft_mosi = r_shift[39];
        if (w_bit_end && w_last_cmd) begin
          w_state_next = (r_n == 3'd0) ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: begin
        busy     = 1'b1;
        tft_cs_n = 1'b0;
        tft_sclk = r_phase;
        tft_mosi = r_shift[39];
        tft_dc   = 1'b1;
        if (w_bit_end && w_last_bit) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy         = 1'b1;
        ack_TFT      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Bit timing, bit counting and frame shifting; request latched on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= 8'd0;
      r_phase   <= 1'b0;
      r_bit_cnt <= 6'd0;
      r_shift   <= 40'd0;
      r_n       <= 3'd0;
    end else if (r_state == ST_IDLE) begin
      r_div     <= 8'd0;
      r_phase   <= 1'b0;
      r_bit_cnt <= 6'd0;
      if (wi_in) begin
        r_n     <= w_n_clamp;
        r_shift <= {addr_in[7:0], w_payload};
      end
    end else if (w_shifting) begin
      if (r_div == c_div_last) begin
        r_div   <= 8'd0;
        r_phase <= ~r_phase;
        // Advancing at the end of the high half makes the next bit appear
        // on the first cycle of the following low half.
        if (r_phase) begin
          r_shift   <= {r_shift[38:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 6'd1;
        end
      end else begin
        r_div <= r_div + 8'd1;
      end
    end else begin
      r_div     <= 8'd0;
      r_phase   <= 1'b0;
      r_bit_cnt <= 6'd0;
      r_shift   <= 40'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_t07_tft_spi_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t07_tft_spi_writer
//  Description : Directed self-checking bench for t07_tft_spi_writer, with
//                one instance at CLK_DIV=2 and one at CLK_DIV=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_t07_tft_spi_writer;

  logic        clk;
  logic        rst;
  logic        wi_in;
  logic [31:0] addr_in;
  logic [31:0] data_in;

  logic ack_s, busy_s, cs_s, sclk_s, mosi_s, dc_s;
  logic ack_f, busy_f, cs_f, sclk_f, mosi_f, dc_f;

  bit   use_fast;
  logic m_ack, m_busy, m_cs_n, m_sclk, m_mosi, m_dc;

  int checks;
  int errors;

  t07_tft_spi_writer #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .wi_in(wi_in), .addr_in(addr_in), .data_in(data_in),
    .ack_TFT(ack_s), .busy(busy_s), .tft_cs_n(cs_s), .tft_sclk(sclk_s),
    .tft_mosi(mosi_s), .tft_dc(dc_s)
  );

  t07_tft_spi_writer #(.CLK_DIV(1)) dut_fast (
    .clk(clk), .rst(rst), .wi_in(wi_in), .addr_in(addr_in), .data_in(data_in),
    .ack_TFT(ack_f), .busy(busy_f), .tft_cs_n(cs_f), .tft_sclk(sclk_f),
    .tft_mosi(mosi_f), .tft_dc(dc_f)
  );

  assign m_ack  = use_fast ? ack_f  : ack_s;
  assign m_busy = use_fast ? busy_f : busy_s;
  assign m_cs_n = use_fast ? cs_f   : cs_s;
  assign m_sclk = use_fast ? sclk_f : sclk_s;
  assign m_mosi = use_fast ? mosi_f : mosi_s;
  assign m_dc   = use_fast ? dc_f   : dc_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observes one transaction. Call at a negedge with the request already
  // driven; the next posedge is the acceptance edge (cycle 0). The request
  // inputs are scrambled after acceptance, and wi_in is pulsed on cycles
  // p1/p2. Capture runs until tail cycles past the first ack (bounded).
  task automatic capture(input int p1, input int p2, input int tail,
                         output logic [39:0] bits, output logic [39:0] dcs,
                         output int nbits, output int ack_cyc, output int nack,
                         output int cs_low, output int busy_cnt);
    logic prev;
    int   stop;
    bits = '0; dcs = '0; nbits = 0; ack_cyc = -1; nack = 0;
    cs_low = 0; busy_cnt = 0; prev = 1'b0; stop = 400;
    @(posedge clk);
    for (int cyc = 1; cyc <= stop; cyc++) begin
      @(negedge clk);
      wi_in = (cyc == p1) || (cyc == p2);
      if (cyc == 1) begin
        addr_in = ~addr_in;
        data_in = ~data_in;
      end
      if (m_cs_n == 1'b0) cs_low++;
      if (m_busy) busy_cnt++;
      if (m_sclk && !prev) begin
        bits = {bits[38:0], m_mosi};
        dcs  = {dcs[38:0], m_dc};
        nbits++;
      end
      prev = m_sclk;
      if (m_ack) begin
        nack++;
        if (ack_cyc < 0) begin
          ack_cyc = cyc;
          stop    = cyc + tail;
        end
      end
    end
    wi_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; wi_in = 1'b0; addr_in = '0; data_in = '0; use_fast = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack_s, busy_s, cs_s, sclk_s, mosi_s, dc_s} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_outputs: got ack,busy,cs_n,sclk,mosi,dc=%b required 001000",
               {ack_s, busy_s, cs_s, sclk_s, mosi_s, dc_s});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack_s, busy_s, cs_s, sclk_s} !== 4'b0010) begin
      errors++;
      $display("FAIL idle_outputs: got ack,busy,cs_n,sclk=%b required 0010",
               {ack_s, busy_s, cs_s, sclk_s});
    end
  endtask

  task automatic test_cmd_only;
    logic [39:0] bits, dcs;
    int nbits, ack_cyc, nack, cs_low, busy_cnt;
    addr_in = 32'h0000_002A; data_in = 32'hDEAD_BEEF; wi_in = 1'b1;
    capture(0, 0, 3, bits, dcs, nbits, ack_cyc, nack, cs_low, busy_cnt);
    checks++;
    if (nbits != 8 || bits[7:0] !== 8'h2A) begin
      errors++;
      $display("FAIL cmd_only_bits: got %0d bits value %h required 8 bits 2a", nbits, bits[7:0]);
    end
    checks++;
    if (dcs !== 40'd0) begin
      errors++;
      $display("FAIL cmd_only_dc: got dc pattern %h required 0", dcs);
    end
    checks++;
    if (ack_cyc != 33 || nack != 1) begin
      errors++;
      $display("FAIL cmd_only_ack: got cycle %0d count %0d required cycle 33 count 1", ack_cyc, nack);
    end
    checks++;
    if (cs_low != 32 || busy_cnt != 33) begin
      errors++;
      $display("FAIL cmd_only_cs_busy: got cs_low %0d busy %0d required 32 33", cs_low, busy_cnt);
    end
  endtask

  task automatic test_two_bytes;
    logic [39:0] bits, dcs;
    int nbits, ack_cyc, nack, cs_low, busy_cnt;
    addr_in = 32'h0000_022B; data_in = 32'h0000_ABCD; wi_in = 1'b1;
    capture(0, 0, 3, bits, dcs, nbits, ack_cyc, nack, cs_low, busy_cnt);
    checks++;
    if (nbits != 24 || bits[23:0] !== 24'h2BABCD) begin
      errors++;
      $display("FAIL two_bytes_bits: got %0d bits value %h required 24 bits 2babcd", nbits, bits[23:0]);
    end
    checks++;
    if (dcs[23:0] !== 24'h00FFFF) begin
      errors++;
      $display("FAIL two_bytes_dc: got dc pattern %h required 00ffff", dcs[23:0]);
    end
    checks++;
    if (ack_cyc != 97 || nack != 1 || cs_low != 96) begin
      errors++;
      $display("FAIL two_bytes_timing: got ack %0d count %0d cs_low %0d required 97 1 96",
               ack_cyc, nack, cs_low);
    end
  endtask

  task automatic test_clamp;
    logic [39:0] bits, dcs;
    int nbits, ack_cyc, nack, cs_low, busy_cnt;
    addr_in = 32'h0000_0755; data_in = 32'h1122_3344; wi_in = 1'b1;
    capture(0, 0, 3, bits, dcs, nbits, ack_cyc, nack, cs_low, busy_cnt);
    checks++;
    if (nbits != 40 || bits !== 40'h55_1122_3344) begin
      errors++;
      $display("FAIL clamp_bits: got %0d bits value %h required 40 bits 5511223344", nbits, bits);
    end
    checks++;
    if (dcs !== 40'h00_FFFF_FFFF) begin
      errors++;
      $display("FAIL clamp_dc: got dc pattern %h required 00ffffffff", dcs);
    end
    checks++;
    if (ack_cyc != 161 || cs_low != 160 || busy_cnt != 161) begin
      errors++;
      $display("FAIL clamp_timing: got ack %0d cs_low %0d busy %0d required 161 160 161",
               ack_cyc, cs_low, busy_cnt);
    end
  endtask

  task automatic test_ignore_retrigger;
    logic [39:0] bits, dcs;
    int nbits, ack_cyc, nack, cs_low, busy_cnt;
    addr_in = 32'h0000_012C; data_in = 32'h0000_00E7; wi_in = 1'b1;
    // Cycle 20 is mid-command, cycle 65 is the DONE cycle.
    capture(20, 65, 8, bits, dcs, nbits, ack_cyc, nack, cs_low, busy_cnt);
    checks++;
    if (nbits != 16 || bits[15:0] !== 16'h2CE7) begin
      errors++;
      $display("FAIL retrig_bits: got %0d bits value %h required 16 bits 2ce7", nbits, bits[15:0]);
    end
    checks++;
    if (ack_cyc != 65 || nack != 1 || cs_low != 64) begin
      errors++;
      $display("FAIL retrig_ignored: got ack %0d count %0d cs_low %0d required 65 1 64",
               ack_cyc, nack, cs_low);
    end
  endtask

  task automatic test_reset_mid;
    logic [39:0] bits, dcs;
    int nbits, ack_cyc, nack, cs_low, busy_cnt;
    int acks_after, cs_after;
    addr_in = 32'h0000_0211; data_in = 32'h0000_FFFF; wi_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wi_in = 1'b0;
    repeat (39) @(negedge clk);
    // Cycle 40 lies in the first data byte.
    checks++;
    if (dc_s !== 1'b1 || cs_s !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_precheck: got dc %b cs_n %b required 1 0", dc_s, cs_s);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ack_s, busy_s, cs_s, sclk_s, mosi_s, dc_s} !== 6'b001000) begin
      errors++;
      $display("FAIL rst_mid_abort: got ack,busy,cs_n,sclk,mosi,dc=%b required 001000",
               {ack_s, busy_s, cs_s, sclk_s, mosi_s, dc_s});
    end
    @(negedge clk);
    rst = 1'b0;
    acks_after = 0; cs_after = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (ack_s) acks_after++;
      if (!cs_s) cs_after++;
    end
    checks++;
    if (acks_after != 0 || cs_after != 0) begin
      errors++;
      $display("FAIL rst_mid_no_ack: got acks %0d cs_low %0d required 0 0", acks_after, cs_after);
    end
    addr_in = 32'h0000_013C; data_in = 32'h0000_005A; wi_in = 1'b1;
    capture(0, 0, 3, bits, dcs, nbits, ack_cyc, nack, cs_low, busy_cnt);
    checks++;
    if (nbits != 16 || bits[15:0] !== 16'h3C5A || dcs[15:0] !== 16'h00FF || ack_cyc != 65) begin
      errors++;
      $display("FAIL rst_mid_recover: got %0d bits %h dc %h ack %0d required 16 3c5a 00ff 65",
               nbits, bits[15:0], dcs[15:0], ack_cyc);
    end
  endtask

  task automatic test_back_to_back;
    int ack1, ack2, nack, sclk_bad;
    logic [7:0] cmd;
    logic prev;
    use_fast = 1'b1;
    ack1 = -1; ack2 = -1; nack = 0; sclk_bad = 0; cmd = '0; prev = 1'b0;
    addr_in = 32'h0000_0096; data_in = '0; wi_in = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc <= 16 && m_sclk !== ((cyc % 2) == 0)) sclk_bad++;
      if (cyc <= 16 && m_sclk && !prev) cmd = {cmd[6:0], m_mosi};
      prev = m_sclk;
      if (m_ack) begin
        nack++;
        if (ack1 < 0) ack1 = cyc;
        else if (ack2 < 0) ack2 = cyc;
      end
      if (cyc == 18) begin
        checks++;
        if (m_cs_n !== 1'b1 || m_busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle_gap: got cs_n %b busy %b at cycle 18 required 1 0", m_cs_n, m_busy);
        end
      end
      if (cyc == 19) begin
        checks++;
        if (m_cs_n !== 1'b0 || m_busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_restart: got cs_n %b busy %b at cycle 19 required 0 1", m_cs_n, m_busy);
        end
      end
    end
    wi_in = 1'b0;
    checks++;
    if (sclk_bad != 0 || cmd !== 8'h96) begin
      errors++;
      $display("FAIL b2b_sclk: got %0d bad sclk cycles cmd %h required 0 96", sclk_bad, cmd);
    end
    checks++;
    if (nack != 2 || ack1 != 17 || ack2 != 35) begin
      errors++;
      $display("FAIL b2b_acks: got count %0d at %0d,%0d required 2 at 17,35", nack, ack1, ack2);
    end
    repeat (60) @(negedge clk);
    use_fast = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cmd_only();
    test_two_bytes();
    test_clamp();
    test_ignore_retrigger();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
